// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared encodings for the cache read/write controllers.
// Revision : 1.0
// ============================================================================
package cache_pkg;

    // List-manager status: only 001 is a hit, every other code is a miss.
    localparam logic [2:0] c_acc_hit     = 3'b001;

    localparam logic [1:0] c_cmd_lookup  = 2'b00;
    localparam logic [1:0] c_cmd_alloc   = 2'b10;
    localparam logic [1:0] c_cmd_touch   = 2'b11;

    localparam logic [2:0] c_proc_none   = 3'b000;
    localparam logic [2:0] c_proc_check  = 3'b001;
    localparam logic [2:0] c_proc_busy   = 3'b010;
    localparam logic [2:0] c_proc_done   = 3'b011;

    typedef enum logic [3:0] {
        S_IDLE           = 4'd0,
        S_LOOKUP         = 4'd1,
        S_CHECK_CONFLICT = 4'd2,
        S_WAIT_CONFLICT  = 4'd3,
        S_ALLOCATE_LINE  = 4'd4,
        S_FETCH_REQ      = 4'd5,
        S_WAIT_FETCH_CMP = 4'd6,
        S_MEM_RD         = 4'd7,
        S_WAIT_DATA      = 4'd8,
        S_RESP           = 4'd9
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rd_ctrl
// Brief    : Cache read controller: lookup, miss allocate/fetch, RAM read.
// Revision : 1.0
// ============================================================================
module rd_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LIST_DEPTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LIST_WIDTH = 32
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               acc_rd_valid,
    output logic                                               acc_rd_ready,
    input  logic [ADDR_WIDTH-1:0]                              acc_rd_addr,
    output logic                                               acc_rd_rvalid,
    input  logic                                               acc_rd_rready,
    output logic [DATA_WIDTH-1:0]                              acc_rd_rdata,
    output logic [ADDR_WIDTH-1:0]                              acc_index,
    input  logic [2:0]                                         acc_status,
    output logic [1:0]                                         acc_cmd,
    output logic [$clog2(LIST_DEPTH)-1:0]                      acc_tag,
    output logic                                               acc_req,
    input  logic [$clog2(LIST_DEPTH)-1:0]                      return_tag,
    input  logic [ADDR_WIDTH-1:0]                              return_index,
    output logic [2:0]                                         proc_status_w,
    output logic [ADDR_WIDTH-1:0]                              proc_addr_w,
    input  logic [2:0]                                         proc_status_r,
    input  logic [ADDR_WIDTH-1:0]                              proc_addr_r,
    output logic [1:0]                                         fetch_cmd,
    output logic                                               fetch_req,
    output logic [$clog2(LIST_DEPTH)-1:0]                      fetch_tag,
    output logic [ADDR_WIDTH-1:0]                              fetch_addr,
    output logic [ADDR_WIDTH-1:0]                              fetch_addr_pre,
    input  logic                                               fetch_gnt,
    input  logic                                               fetch_done,
    output logic [$clog2(LIST_DEPTH)+$clog2(LIST_WIDTH)-1:0]   mem_raddr,
    output logic                                               mem_ren,
    input  logic                                               mem_rready,
    input  logic                                               mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                              mem_rdata
);

    localparam int TAG_WIDTH  = $clog2(LIST_DEPTH);
    localparam int OFF_WIDTH  = $clog2(LIST_WIDTH);
    localparam int BYTE_WIDTH = $clog2(DATA_WIDTH/8);
    localparam int LINE_LSB   = OFF_WIDTH + BYTE_WIDTH;

    rd_state_e              r_state;
    rd_state_e              w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  r_victim;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [1:0]             r_fetch_cmd;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_miss;

    logic                   w_hit;
    logic                   w_conflict;
    logic                   w_cap_addr;
    logic                   w_cap_tag;
    logic                   w_cap_alloc;
    logic                   w_cap_data;
    logic [ADDR_WIDTH-1:0]  w_req_line;
    logic [ADDR_WIDTH-1:0]  w_own_line;
    logic                   w_unused;

    assign w_req_line = {acc_rd_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
    assign w_own_line = {r_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
    assign w_hit      = (acc_status == c_acc_hit);

    // Reader yields to a writer that is checking or working on the same line.
    assign w_conflict = (proc_addr_r == w_own_line) &&
                        ((proc_status_r == c_proc_check) || (proc_status_r == c_proc_busy));

    // Byte-within-word bits are carried but never addressed.
    assign w_unused   = ^r_addr[BYTE_WIDTH-1:0];

    assign acc_tag        = r_tag;
    assign fetch_tag      = r_tag;
    assign fetch_addr     = w_own_line;
    assign fetch_addr_pre = r_victim;
    assign fetch_cmd      = r_fetch_cmd;
    assign mem_raddr      = {r_tag, r_addr[LINE_LSB-1:BYTE_WIDTH]};
    assign acc_rd_rdata   = r_data;
    assign proc_addr_w    = (r_state == S_IDLE) ? '0 : w_own_line;
    assign acc_index      = (r_state != S_IDLE) ? w_own_line :
                            (acc_rd_valid ? w_req_line : '0);

    always_comb begin
        w_state_nxt   = r_state;
        acc_rd_ready  = 1'b0;
        acc_rd_rvalid = 1'b0;
        acc_req       = 1'b0;
        acc_cmd       = c_cmd_lookup;
        proc_status_w = c_proc_none;
        fetch_req     = 1'b0;
        mem_ren       = 1'b0;
        w_cap_addr    = 1'b0;
        w_cap_tag     = 1'b0;
        w_cap_alloc   = 1'b0;
        w_cap_data    = 1'b0;

        case (r_state)
            S_IDLE: begin
                acc_rd_ready = 1'b1;
                if (acc_rd_valid) begin
                    acc_req    = 1'b1;
                    w_cap_addr = 1'b1;
                    if (w_hit) begin
                        w_cap_tag   = 1'b1;
                        w_state_nxt = S_MEM_RD;
                    end else begin
                        w_state_nxt = S_CHECK_CONFLICT;
                    end
                end
            end
            S_LOOKUP: begin
                acc_req = 1'b1;
                if (w_hit) begin
                    w_cap_tag   = 1'b1;
                    w_state_nxt = S_MEM_RD;
                end else begin
                    w_state_nxt = S_CHECK_CONFLICT;
                end
            end
            S_CHECK_CONFLICT: begin
                proc_status_w = c_proc_check;
                w_state_nxt   = w_conflict ? S_WAIT_CONFLICT : S_ALLOCATE_LINE;
            end
            S_WAIT_CONFLICT: begin
                if (proc_status_r == c_proc_done) begin
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_ALLOCATE_LINE: begin
                acc_req       = 1'b1;
                acc_cmd       = c_cmd_alloc;
                proc_status_w = c_proc_busy;
                w_cap_alloc   = 1'b1;
                w_state_nxt   = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                fetch_req     = 1'b1;
                proc_status_w = c_proc_busy;
                if (fetch_gnt) begin
                    w_state_nxt = S_WAIT_FETCH_CMP;
                end
            end
            S_WAIT_FETCH_CMP: begin
                proc_status_w = c_proc_busy;
                if (fetch_done) begin
                    w_state_nxt = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_ren       = 1'b1;
                proc_status_w = r_miss ? c_proc_busy : c_proc_none;
                if (mem_rready) begin
                    acc_req       = 1'b1;
                    acc_cmd       = c_cmd_touch;
                    proc_status_w = r_miss ? c_proc_done : c_proc_none;
                    w_state_nxt   = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (mem_rvalid) begin
                    w_cap_data  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                acc_rd_rvalid = 1'b1;
                if (acc_rd_rready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_victim    <= '0;
            r_tag       <= '0;
            r_fetch_cmd <= '0;
            r_data      <= '0;
            r_miss      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap_addr) begin
                r_addr <= acc_rd_addr;
                r_miss <= 1'b0;
            end
            if (w_cap_tag) begin
                r_tag <= return_tag;
            end
            if (w_cap_alloc) begin
                r_tag       <= return_tag;
                r_victim    <= return_index;
                r_fetch_cmd <= acc_status[1:0];
                r_miss      <= 1'b1;
            end
            if (w_cap_data) begin
                r_data <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
